// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select pipeline: source-select
// encodings and the RISC-V load funct3 codes used by load extraction.
package wb_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_IMM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the addressed byte/half/word
// out of the memory read data and sign- or zero-extends it to XLEN.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension per load type
    always_comb begin
        byte_sel = mem[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? mem[31:16] : mem[15:0];
        data     = mem;
        case (funct3)
            F3_LB:   data = XLEN'($signed(byte_sel));
            F3_LH:   data = XLEN'($signed(half_sel));
            F3_LW:   data = XLEN'($signed(mem[31:0]));
            F3_LBU:  data = XLEN'(byte_sel);
            F3_LHU:  data = XLEN'(half_sel);
            default: data = mem;
        endcase
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back source select with a small in-order result FIFO.
// Data is selected at push time and stored, so the head entry drives the
// register-file write port directly. Writes to x0 are suppressed on entry.
// Optional feature: define WB_LOAD_EXT_EN to extract/extend MEM load data
// by funct3 and byte offset; otherwise MEM data passes through unchanged.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [4:0]      in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_we
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] sel_data;
    logic            push;
    logic            pop;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] data_q [DEPTH];
    logic [4:0]      rd_q   [DEPTH];
    logic            we_q   [DEPTH];

`ifdef WB_LOAD_EXT_EN
    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .mem     (in_mem),
        .data    (mem_data)
    );
`else
    logic unused_load_cfg;
    assign unused_load_cfg = ^{in_funct3, in_addr_lo};
    assign mem_data        = in_mem;
`endif

    // Source mux; PC+4 wraps at 2^XLEN with the carry dropped
    always_comb begin
        sel_data = in_alu;
        case (in_sel)
            WB_SRC_ALU: sel_data = in_alu;
            WB_SRC_MEM: sel_data = mem_data;
            WB_SRC_PC4: sel_data = in_pc + XLEN'(4);
            WB_SRC_IMM: sel_data = in_imm;
            default:    sel_data = in_alu;
        endcase
    end

    // Handshakes; a full buffer still accepts when the head leaves this cycle
    always_comb begin
        in_ready  = (count < DEPTH_C) || out_ready;
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Head entry to the write port, forced to zero while empty or in reset
    always_comb begin
        out_data = '0;
        out_rd   = '0;
        out_we   = 1'b0;
        if (out_valid) begin
            out_data = data_q[rd_ptr];
            out_rd   = rd_q[rd_ptr];
            out_we   = we_q[rd_ptr];
        end
    end

    // Entry storage; contents are only observable through count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= sel_data;
            rd_q[wr_ptr]   <= in_rd;
            we_q[wr_ptr]   <= in_we && (in_rd != 5'd0);
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
